// File: rtl/bsg_serial_in_parallel_out_assembler_if.sv
// rtl/bsg_serial_in_parallel_out_assembler_if.sv - word-in / group-out handshake bundle
// Signal directions are named from the assembler's point of view.
interface bsg_serial_in_parallel_out_assembler_if #(
  parameter int width_p = -1,
  parameter int els_p   = -1
);
  logic                           valid_i;
  logic [width_p-1:0]             data_i;
  logic                           yumi_o;
  logic                           valid_o;
  logic [els_p-1:0][width_p-1:0]  data_o;
  logic                           ready_i;

  modport slave (
    input  valid_i, data_i, ready_i,
    output yumi_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  yumi_o, valid_o, data_o
  );
endinterface

// File: rtl/bsg_serial_in_parallel_out_assembler.sv
// rtl/bsg_serial_in_parallel_out_assembler.sv - collects els_p serial words into one parallel group
// Optional BSG_SIPO_ASM_FLUSH_EN adds flush_i, which discards the partially assembled group.
module bsg_serial_in_parallel_out_assembler #(
  parameter int width_p        = -1,
  parameter int els_p          = -1,
  parameter int msb_then_lsb_p = 0
) (
  input  logic clk_i,
  input  logic reset_n_i,
`ifdef BSG_SIPO_ASM_FLUSH_EN
  input  logic flush_i,
`endif
  bsg_serial_in_parallel_out_assembler_if.slave sipo
);

  localparam int cnt_w_lp = $clog2(els_p);
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(els_p - 1);

  typedef logic [els_p-1:0][width_p-1:0] group_t;

  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  group_t              asm_q, asm_d;
  group_t              out_q, out_d;
  logic                out_v_q, out_v_d;
  logic [cnt_w_lp-1:0] idx;
  logic                last_word;
  logic                yumi;

  assign idx       = (msb_then_lsb_p != 0) ? (last_lp - cnt_q) : cnt_q;
  assign last_word = (cnt_q == last_lp);

  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    out_d   = out_q;
    out_v_d = out_v_q;

    // The final word may only land when the output slot is free or draining now.
    yumi = reset_n_i & sipo.valid_i & (~last_word | ~out_v_q | sipo.ready_i);
`ifdef BSG_SIPO_ASM_FLUSH_EN
    if (flush_i) begin
      yumi = 1'b0;
    end
`endif

    if (out_v_q & sipo.ready_i) begin
      out_v_d = 1'b0;
    end

    if (yumi) begin
      if (last_word) begin
        out_d      = asm_q;
        out_d[idx] = sipo.data_i;
        out_v_d    = 1'b1;
        cnt_d      = '0;
      end else begin
        asm_d[idx] = sipo.data_i;
        cnt_d      = cnt_q + cnt_w_lp'(1);
      end
    end

`ifdef BSG_SIPO_ASM_FLUSH_EN
    if (flush_i) begin
      cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
    end
  end

  assign sipo.yumi_o  = yumi;
  assign sipo.valid_o = out_v_q;
  assign sipo.data_o  = out_q;

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_assembler.sv
// tb/tb_bsg_serial_in_parallel_out_assembler.sv - self-checking bench for the SIPO assembler
// Three instances share stimulus: (els 4, lsb first), (els 4, msb first), (els 3, lsb first).
module tb_bsg_serial_in_parallel_out_assembler;

  logic       clk = 1'b0;
  logic       rst_n, valid, ready, flush;
  logic [7:0] data;

  always #5 clk = ~clk;

  bsg_serial_in_parallel_out_assembler_if #(.width_p(8), .els_p(4)) ifc0 ();
  bsg_serial_in_parallel_out_assembler_if #(.width_p(8), .els_p(4)) ifc1 ();
  bsg_serial_in_parallel_out_assembler_if #(.width_p(8), .els_p(3)) ifc2 ();

  assign ifc0.valid_i = valid;  assign ifc0.data_i = data;  assign ifc0.ready_i = ready;
  assign ifc1.valid_i = valid;  assign ifc1.data_i = data;  assign ifc1.ready_i = ready;
  assign ifc2.valid_i = valid;  assign ifc2.data_i = data;  assign ifc2.ready_i = ready;

  bsg_serial_in_parallel_out_assembler #(.width_p(8), .els_p(4), .msb_then_lsb_p(0)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n),
`ifdef BSG_SIPO_ASM_FLUSH_EN
    .flush_i(flush),
`endif
    .sipo(ifc0.slave));

  bsg_serial_in_parallel_out_assembler #(.width_p(8), .els_p(4), .msb_then_lsb_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n),
`ifdef BSG_SIPO_ASM_FLUSH_EN
    .flush_i(flush),
`endif
    .sipo(ifc1.slave));

  bsg_serial_in_parallel_out_assembler #(.width_p(8), .els_p(3), .msb_then_lsb_p(0)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n),
`ifdef BSG_SIPO_ASM_FLUSH_EN
    .flush_i(flush),
`endif
    .sipo(ifc2.slave));

  logic        yumi_a [3];
  logic        vo_a   [3];
  logic [31:0] do_a   [3];
  assign yumi_a[0] = ifc0.yumi_o;  assign vo_a[0] = ifc0.valid_o;  assign do_a[0] = ifc0.data_o;
  assign yumi_a[1] = ifc1.yumi_o;  assign vo_a[1] = ifc1.valid_o;  assign do_a[1] = ifc1.data_o;
  assign yumi_a[2] = ifc2.yumi_o;  assign vo_a[2] = ifc2.valid_o;  assign do_a[2] = {8'h00, ifc2.data_o};

  // Reference model: words collected so far, plus the presented group.
  int          els_m [3] = '{4, 4, 3};
  int          msb_m [3] = '{0, 1, 0};
  logic [7:0]  part_m[3][$];
  bit          out_v_m[3];
  logic [31:0] out_m [3];

  int n_pass  = 0;
  int n_total = 0;

  function automatic bit exp_yumi(int k);
    return rst_n && valid && !flush &&
           (part_m[k].size() != els_m[k] - 1 || !out_v_m[k] || ready);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      part_m[k].delete();
      out_v_m[k] = 1'b0;
      out_m[k]   = '0;
    end
  endfunction

  function automatic void model_edge();
    bit y;
    int s;
    for (int k = 0; k < 3; k++) begin
      y = exp_yumi(k);
      if (out_v_m[k] && ready) out_v_m[k] = 1'b0;
      if (y) begin
        part_m[k].push_back(data);
        if (part_m[k].size() == els_m[k]) begin
          out_m[k] = '0;
          for (int i = 0; i < els_m[k]; i++) begin
            s = (msb_m[k] != 0) ? els_m[k] - 1 - i : i;
            out_m[k][8*s +: 8] = part_m[k][i];
          end
          out_v_m[k] = 1'b1;
          part_m[k].delete();
        end
      end
      if (flush) part_m[k].delete();
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    valid = 1'b1; ready = 1'b0; flush = 1'b0; data = 8'hA5; rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if ({yumi_a[k], vo_a[k], do_a[k]} !== {1'b0, 1'b0, 32'h0})
          $display("FAIL reset dut%0d: got yumi=%b v=%b d=%h, need 0 0 0", k, yumi_a[k], vo_a[k], do_a[k]);
        else n_pass++;
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic [7:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      valid = (i < 4);
      data  = (i < 4) ? words[i] : 8'h00;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if ({yumi_a[k], vo_a[k], do_a[k]} !== {exp_yumi(k), out_v_m[k], out_m[k]})
          $display("FAIL stream dut%0d cyc%0d: got %b %b %h, need %b %b %h", k, i,
                   yumi_a[k], vo_a[k], do_a[k], exp_yumi(k), out_v_m[k], out_m[k]);
        else n_pass++;
      end
      if (i == 4) begin
        n_total++;
        if ({vo_a[0], do_a[0]} !== {1'b1, 32'h44332211})
          $display("FAIL stream_lsb_first: got v=%b d=%h, need 1 44332211", vo_a[0], do_a[0]);
        else n_pass++;
        n_total++;
        if ({vo_a[1], do_a[1]} !== {1'b1, 32'h11223344})
          $display("FAIL stream_msb_first: got v=%b d=%h, need 1 11223344", vo_a[1], do_a[1]);
        else n_pass++;
        n_total++;
        if (do_a[2] !== 32'h00332211)
          $display("FAIL stream_els3: got d=%h, need 00332211", do_a[2]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int acc0, acc2;
    acc0 = 0; acc2 = 0;
    for (int i = 0; i < 16; i++) begin
      valid = (i < 13);
      ready = (i >= 12);
      data  = 8'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if ({yumi_a[k], vo_a[k], do_a[k]} !== {exp_yumi(k), out_v_m[k], out_m[k]})
          $display("FAIL backpressure dut%0d cyc%0d: got %b %b %h, need %b %b %h", k, i,
                   yumi_a[k], vo_a[k], do_a[k], exp_yumi(k), out_v_m[k], out_m[k]);
        else n_pass++;
      end
      if (i < 12) begin
        acc0 += int'(yumi_a[0]);
        acc2 += int'(yumi_a[2]);
      end
      if (i == 12) begin
        n_total++;
        if (yumi_a[0] !== 1'b1) $display("FAIL bp_release_yumi: got %b, need 1", yumi_a[0]);
        else n_pass++;
      end
      tick();
    end
    n_total++;
    if (acc0 != 7) $display("FAIL bp_accepted_els4: got %0d, need 7", acc0);
    else n_pass++;
    n_total++;
    if (acc2 != 4) $display("FAIL bp_accepted_els3: got %0d, need 4", acc2);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 2) != 0);
      data  = 8'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if ({yumi_a[k], vo_a[k], do_a[k]} !== {exp_yumi(k), out_v_m[k], out_m[k]})
          $display("FAIL random dut%0d cyc%0d: got %b %b %h, need %b %b %h", k, i,
                   yumi_a[k], vo_a[k], do_a[k], exp_yumi(k), out_v_m[k], out_m[k]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reset_midgroup();
    logic [7:0] w [6];
    for (int j = 0; j < 6; j++) w[j] = 8'($urandom);
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rst_n = !(i == 0 || i == 3);
      if (!rst_n) model_reset();
      valid = (i < 8);
      data  = (i == 1 || i == 2) ? w[i-1] : (i >= 4 && i < 8) ? w[i-2] : 8'h5A;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if ({yumi_a[k], vo_a[k], do_a[k]} !== {exp_yumi(k), out_v_m[k], out_m[k]})
          $display("FAIL reset_mid dut%0d cyc%0d: got %b %b %h, need %b %b %h", k, i,
                   yumi_a[k], vo_a[k], do_a[k], exp_yumi(k), out_v_m[k], out_m[k]);
        else n_pass++;
      end
      if (i == 8) begin
        n_total++;
        if ({vo_a[0], do_a[0]} !== {1'b1, w[5], w[4], w[3], w[2]})
          $display("FAIL reset_mid_group: got v=%b d=%h, need 1 %h", vo_a[0], do_a[0],
                   {w[5], w[4], w[3], w[2]});
        else n_pass++;
      end
      tick();
    end
  endtask

`ifdef BSG_SIPO_ASM_FLUSH_EN
  task automatic test_flush();
    logic [7:0] w [6];
    for (int j = 0; j < 6; j++) w[j] = 8'($urandom);
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rst_n = (i != 0);
      if (!rst_n) model_reset();
      flush = (i == 3);
      valid = (i >= 1 && i < 8);
      data  = (i == 1 || i == 2) ? w[i-1] : (i >= 4 && i < 8) ? w[i-2] : 8'hC3;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if ({yumi_a[k], vo_a[k], do_a[k]} !== {exp_yumi(k), out_v_m[k], out_m[k]})
          $display("FAIL flush dut%0d cyc%0d: got %b %b %h, need %b %b %h", k, i,
                   yumi_a[k], vo_a[k], do_a[k], exp_yumi(k), out_v_m[k], out_m[k]);
        else n_pass++;
      end
      if (i == 3) begin
        n_total++;
        if (yumi_a[0] !== 1'b0) $display("FAIL flush_yumi: got %b, need 0", yumi_a[0]);
        else n_pass++;
      end
      if (i == 8) begin
        n_total++;
        if ({vo_a[0], do_a[0]} !== {1'b1, w[5], w[4], w[3], w[2]})
          $display("FAIL flush_group: got v=%b d=%h, need 1 %h", vo_a[0], do_a[0],
                   {w[5], w[4], w[3], w[2]});
        else n_pass++;
      end
      tick();
    end
    flush = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; valid = 1'b0; ready = 1'b0; flush = 1'b0; data = 8'h00;
    model_reset();
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_reset_midgroup();
`ifdef BSG_SIPO_ASM_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bsg_serial_in_parallel_out_assembler.md
# bsg_serial_in_parallel_out_assembler

Reassembles a stream of `width_p`-bit words into `els_p`-word parallel groups. It is the receive-side counterpart of the parallel-in/serial-out serializer and consumes that serializer's valid-then-yumi output directly. Holding one completed group in an output register lets assembly of the next group overlap with draining of the current one, so sustained throughput is one word per cycle.

## Interface
Parameters:
- `width_p`, no default (-1, must be set): word width in bits.
- `els_p`, no default (-1, must be set, ≥2): words per group.
- `msb_then_lsb_p`, default 0: 0 means the first word received lands in slot 0; 1 means it lands in slot `els_p-1`.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous active-low reset.
- `valid_i`  in  1  input word valid.
- `data_i`  in  `width_p`  input word.
- `yumi_o`  out  1  input word consumed this cycle.
- `valid_o`  out  1  completed group available.
- `data_o`  out  `els_p` × `width_p`  completed group, packed as `[els_p-1:0][width_p-1:0]`.
- `ready_i`  in  1  consumer accepts group (ready-and-valid).
- `flush_i`  in  1  present only with `BSG_SIPO_ASM_FLUSH_EN`; discards the partial group.

## Operation
State:
- `cnt_r`, `$clog2(els_p)` bits: count of words held in the assembly array.
- `asm_r`: the `els_p`-word assembly array.
- `out_r`: output group register.
- `out_v_r`: output register occupied.

Slot index:
- `idx = cnt_r` when `msb_then_lsb_p == 0`.
- `idx = els_p-1-cnt_r` otherwise.

Input handshake:
- `yumi_o = valid_i & (cnt_r != els_p-1 | ~out_v_r | ready_i)`.
- A non-final word is accepted whenever it is valid.
- The final word is accepted only if the output register is empty or is being drained in the same cycle.
- This is a combinational path from `ready_i` to `yumi_o`. It is permitted.

On acceptance of a non-final word (`cnt_r < els_p-1`):
- `asm_r[idx] <= data_i`.
- `cnt_r <= cnt_r+1`.

On acceptance of the final word (`cnt_r == els_p-1`):
- `out_r <= asm_r` with slot `idx` replaced by `data_i`.
- `out_v_r <= 1`.
- `cnt_r <= 0`.
- `asm_r` is not cleared.

Output side:
- `valid_o = out_v_r`.
- `data_o = out_r`.
- If `valid_o & ready_i` occurs and no final word is accepted in the same cycle, then `out_v_r <= 0`.
- If a final word is accepted in the same cycle, the drain and the load happen together and `out_v_r` stays 1.
- `data_o` is stable while `valid_o & ~ready_i`.

Counter arithmetic:
- `cnt_r` never exceeds `els_p-1`.
- The wrap from `els_p-1` to 0 happens only on final-word acceptance.
- Non-power-of-two `els_p` is supported.

## Timing
- Reset (asynchronous assert, synchronous release) clears `cnt_r`, `asm_r`, `out_r` and `out_v_r`.
- While `reset_n_i` is low: `valid_o` is 0, `data_o` is 0 and `yumi_o` is 0, whatever the value of `valid_i`.
- Latency: the final word is accepted on the edge ending cycle N; `valid_o` is 1 in cycle N+1.
- Throughput: with `ready_i` held at 1, `yumi_o` is 1 every cycle that `valid_i` is 1. One group is produced per `els_p` accepted words.
- Backpressure: if `out_v_r` is 1 and `ready_i` is 0, the block keeps accepting words until `cnt_r == els_p-1`, then holds `yumi_o` at 0 until `ready_i` rises.
- Reset asserted mid-group: the partial group and any pending output are discarded. After release, the first word accepted goes to the first slot.

## Configuration
- `BSG_SIPO_ASM_FLUSH_EN` defined:
  - The `flush_i` port exists.
  - In any cycle with `flush_i` at 1: `yumi_o` is forced to 0 and `cnt_r <= 0`.
  - `asm_r` contents are don't-care after a flush.
  - `out_r` and `out_v_r` are unaffected, so the output handshake proceeds normally.
- `BSG_SIPO_ASM_FLUSH_EN` undefined: there is no `flush_i` port and no flush logic.

## Test plan
- Streaming: `width_p=8`, `els_p=4`, `msb_then_lsb_p=0`, `ready_i=1`, inputs `0x11,0x22,0x33,0x44` on consecutive cycles. Required: `yumi_o` is 1 on all four cycles; one cycle after `0x44`, `valid_o` is 1 with `data_o = {0x44,0x33,0x22,0x11}` (slot 3 down to slot 0) for exactly one cycle.
- Ordering: same stimulus with `msb_then_lsb_p=1`. Required: `data_o = {0x11,0x22,0x33,0x44}`.
- Backpressure: `ready_i=0` for 12 cycles while `valid_i=1` with `els_p=4`. Required: the first group appears; words 5–7 are accepted; word 8 sees `yumi_o=0` until `ready_i=1`; on that cycle `yumi_o=1`, and the second group appears in the next cycle with `valid_o` never dropping.
- Non-power-of-two: `els_p=3`, nine back-to-back words. Required: three groups, `cnt_r` wraps 2→0 each time, no word is dropped or duplicated.
- Reset: `reset_n_i` pulsed low after 2 of 4 words, with `valid_i` held at 1. Required: `valid_o=0` and `yumi_o=0` during reset; the next 4 words after release form a complete, correct group.
- Flush (macro defined): 2 words, then `flush_i=1` for one cycle, then 4 words. Required: `yumi_o=0` during the flush cycle; the single group output contains only the last 4 words.
